// File: rtl/clkgen_pkg.sv
// Shared definitions for the two-phase clock generator: FSM states,
// the cycle counter width and the phase outputs driven in each state.
package clkgen_pkg;

   // Width of the completed-cycle counter presented on o_cycle_cnt.
   localparam int CYC_CNT_W = 16;

   // One full phase cycle walks P1 -> D1 -> P2 -> D2; HALT parks between runs.
   typedef enum logic [2:0] {
      HALT = 3'd0,
      P1   = 3'd1,
      D1   = 3'd2,
      P2   = 3'd3,
      D2   = 3'd4
   } state_t;

   // Phase enables asserted while sitting in a given state.
   typedef struct packed {
      logic phi1;
      logic phi2;
   } phase_t;

   // Only P1 and P2 drive a phase; every other state holds both low.
   function automatic phase_t phase_enc(input state_t s);
      phase_t p;
      p = '0;
      case (s)
         P1:      p.phi1 = 1'b1;
         P2:      p.phi2 = 1'b1;
         default: p = '0;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter that times how long the FSM stays in a state.
// The FSM loads (duration-1) on state entry and leaves when o_zero is set.
module phase_counter #(
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   // Load on request, otherwise count down and rest at zero.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/two_phase_clkgen.sv
// Two-phase non-overlapping clock generator with run/halt/single-step
// control. Every output is a flop so each enable pair stays glitch-free and
// complementary on every cycle.
module two_phase_clkgen
   import clkgen_pkg::*;
#(
   parameter int HIGH_CYC = 2,
   parameter int DEAD_CYC = 1,
   parameter int CNT_W    = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_run,
   input  logic                 i_step,
   output logic                 o_phi1,
   output logic                 o_nphi1,
   output logic                 o_phi2,
   output logic                 o_nphi2,
   output logic                 o_halted,
   output logic                 o_step_ack,
   output logic [CYC_CNT_W-1:0] o_cycle_cnt
);

   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // Durations must fit the phase counter; a zero dead time would let the
   // phases touch, so it is refused outright.
   generate
      if (HIGH_CYC < 1 || HIGH_CYC > CNT_MAX) begin : g_bad_high_cyc
         $error("two_phase_clkgen: HIGH_CYC outside 1..2^CNT_W-1");
      end
      if (DEAD_CYC < 1 || DEAD_CYC > CNT_MAX) begin : g_bad_dead_cyc
         $error("two_phase_clkgen: DEAD_CYC outside 1..2^CNT_W-1");
      end
   endgenerate

   localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic                 r_stepping;
   logic                 w_stepping_next;
   logic                 r_step;
   logic                 r_step_edge;
   logic                 w_cnt_load;
   logic [CNT_W-1:0]     w_cnt_load_val;
   logic                 w_cnt_zero;
   logic                 w_cycle_done;
   logic                 w_ack_next;
   phase_t               w_phase_next;

   logic                 r_phi1;
   logic                 r_nphi1;
   logic                 r_phi2;
   logic                 r_nphi2;
   logic                 r_halted;
   logic                 r_step_ack;
   logic [CYC_CNT_W-1:0] r_cycle_cnt;

   phase_counter #(
      .CNT_W      (CNT_W)
   ) u_phase_counter (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_cnt_load),
      .i_load_val (w_cnt_load_val),
      .o_zero     (w_cnt_zero)
   );

   // State register, stepped-cycle flag and STEP edge detector. The edge is
   // registered so HALT reacts one cycle after STEP is seen rising; a pulse
   // arriving outside HALT or alongside RUN simply expires unused.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= HALT;
         r_stepping  <= 1'b0;
         r_step      <= 1'b0;
         r_step_edge <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_stepping  <= w_stepping_next;
         r_step      <= i_step;
         r_step_edge <= i_step & ~r_step;
      end
   end

   // Next-state decode: RUN beats a step request in HALT, a stepped cycle
   // always returns to HALT, and no phase is ever cut short.
   always_comb begin
      w_state_next    = r_state;
      w_stepping_next = r_stepping;
      w_cycle_done    = 1'b0;
      w_ack_next      = 1'b0;
      case (r_state)
         HALT: begin
            if (i_run) begin
               w_state_next    = P1;
               w_stepping_next = 1'b0;
            end else if (r_step_edge) begin
               w_state_next    = P1;
               w_stepping_next = 1'b1;
            end
         end
         P1: if (w_cnt_zero) w_state_next = D1;
         D1: if (w_cnt_zero) w_state_next = P2;
         P2: if (w_cnt_zero) w_state_next = D2;
         D2: begin
            if (w_cnt_zero) begin
               w_cycle_done = 1'b1;
               if (i_run && !r_stepping) begin
                  w_state_next = P1;
               end else begin
                  w_state_next    = HALT;
                  w_ack_next      = r_stepping;
                  w_stepping_next = 1'b0;
               end
            end
         end
         default: begin
            w_state_next    = HALT;
            w_stepping_next = 1'b0;
         end
      endcase
   end

   // Reload the duration counter whenever a new state is entered.
   always_comb begin
      w_cnt_load     = (w_state_next != r_state);
      w_cnt_load_val = '0;
      case (w_state_next)
         P1, P2:  w_cnt_load_val = HIGH_LOAD;
         D1, D2:  w_cnt_load_val = DEAD_LOAD;
         default: w_cnt_load_val = '0;
      endcase
   end

   assign w_phase_next = phase_enc(w_state_next);

   // Output flops are loaded from the next state so they line up with it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_phi1      <= 1'b0;
         r_nphi1     <= 1'b1;
         r_phi2      <= 1'b0;
         r_nphi2     <= 1'b1;
         r_halted    <= 1'b1;
         r_step_ack  <= 1'b0;
         r_cycle_cnt <= '0;
      end else begin
         r_phi1     <= w_phase_next.phi1;
         r_nphi1    <= ~w_phase_next.phi1;
         r_phi2     <= w_phase_next.phi2;
         r_nphi2    <= ~w_phase_next.phi2;
         r_halted   <= (w_state_next == HALT);
         r_step_ack <= w_ack_next;
         if (w_cycle_done) begin
            r_cycle_cnt <= r_cycle_cnt + CYC_CNT_W'(1);
         end
      end
   end

   assign o_phi1      = r_phi1;
   assign o_nphi1     = r_nphi1;
   assign o_phi2      = r_phi2;
   assign o_nphi2     = r_nphi2;
   assign o_halted    = r_halted;
   assign o_step_ack  = r_step_ack;
   assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_two_phase_clkgen.sv
// Bench for two_phase_clkgen: a default instance and a HIGH_CYC=3/DEAD_CYC=2
// instance share RUN/STEP. A position-in-period model predicts every cycle's
// outputs into per-instance queues that a monitor drains and compares.
module tb_two_phase_clkgen;

   localparam int HA = 2, DA = 1, HB = 3, DB = 2;

   logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, step = 1'b0;
   logic a_phi1, a_nphi1, a_phi2, a_nphi2, a_halted, a_ack;
   logic b_phi1, b_nphi1, b_phi2, b_nphi2, b_halted, b_ack;
   logic [15:0] a_cnt, b_cnt;

   always #5 clk = ~clk;

   two_phase_clkgen dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step),
      .o_phi1(a_phi1), .o_nphi1(a_nphi1), .o_phi2(a_phi2), .o_nphi2(a_nphi2),
      .o_halted(a_halted), .o_step_ack(a_ack), .o_cycle_cnt(a_cnt));

   two_phase_clkgen #(.HIGH_CYC(HB), .DEAD_CYC(DB), .CNT_W(4)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_step(step),
      .o_phi1(b_phi1), .o_nphi1(b_nphi1), .o_phi2(b_phi2), .o_nphi2(b_nphi2),
      .o_halted(b_halted), .o_step_ack(b_ack), .o_cycle_cnt(b_cnt));

   // Reference: where we are inside the period, not which FSM state.
   typedef struct {
      int          h;
      int          d;
      bit          halted;
      int          pos;
      bit          stepping;
      bit          step_prev;
      bit          step_pend;
      logic [15:0] cnt;
      bit          ack;
   } mdl_t;

   typedef logic [21:0] obs_t;

   mdl_t ma, mb;
   obs_t qa[$], qb[$];
   int   n_cmp = 0, n_bad = 0;
   int   ack_a = 0, ack_b = 0;
   bit   seen_wrap = 0;
   logic [15:0] prev_a_cnt = 16'h0, prev_b_cnt = 16'h0;
   int   low_run[2];
   bit   had_ph[2];
   bit   prev_any[2];

   function automatic mdl_t mdl_reset(input int h, input int d);
      mdl_t m;
      m.h = h; m.d = d; m.halted = 1'b1; m.pos = 0; m.stepping = 1'b0;
      m.step_prev = 1'b0; m.step_pend = 1'b0; m.cnt = 16'h0; m.ack = 1'b0;
      return m;
   endfunction

   // Advance one master clock edge with RUN/STEP as sampled on that edge.
   function automatic mdl_t mdl_next(input mdl_t m, input bit r, input bit s);
      mdl_t n = m;
      n.step_pend = s && !m.step_prev;
      n.step_prev = s;
      n.ack = 1'b0;
      if (m.halted) begin
         if (r) begin
            n.halted = 1'b0; n.pos = 0; n.stepping = 1'b0;
         end else if (m.step_pend) begin
            n.halted = 1'b0; n.pos = 0; n.stepping = 1'b1;
         end
      end else if (m.pos == 2 * (m.h + m.d) - 1) begin
         n.cnt = m.cnt + 16'd1;
         if (r && !m.stepping) begin
            n.pos = 0;
         end else begin
            n.halted = 1'b1; n.ack = m.stepping; n.stepping = 1'b0;
         end
      end else begin
         n.pos = m.pos + 1;
      end
      return n;
   endfunction

   function automatic obs_t mdl_out(input mdl_t m);
      bit p1, p2;
      p1 = !m.halted && (m.pos < m.h);
      p2 = !m.halted && (m.pos >= m.h + m.d) && (m.pos < 2 * m.h + m.d);
      return {p1, !p1, p2, !p2, m.halted, m.ack, m.cnt};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Overlap and dead-time watch, independent of the reference model.
   task automatic gap_chk(input int i, input logic p1, input logic p2, input int d);
      chk(i == 0 ? "a overlap" : "b overlap", 32'(p1 & p2), 32'h0);
      if (p1 | p2) begin
         if (!prev_any[i] && had_ph[i]) begin
            n_cmp++;
            if (low_run[i] < d) begin
               n_bad++;
               $display("FAIL %s dead gap: got %0d cycles, need >= %0d", i == 0 ? "a" : "b", low_run[i], d);
            end
         end
         had_ph[i] = 1'b1; low_run[i] = 0; prev_any[i] = 1'b1;
      end else begin
         low_run[i]++; prev_any[i] = 1'b0;
      end
   endtask

   // Monitor: one expected record per edge per instance, sampled after it.
   always @(posedge clk) begin
      #1;
      if (qa.size() > 0)
         chk("dut_a outputs", 32'({a_phi1, a_nphi1, a_phi2, a_nphi2, a_halted, a_ack, a_cnt}), 32'(qa.pop_front()));
      if (qb.size() > 0)
         chk("dut_b outputs", 32'({b_phi1, b_nphi1, b_phi2, b_nphi2, b_halted, b_ack, b_cnt}), 32'(qb.pop_front()));
      gap_chk(0, a_phi1, a_phi2, DA);
      gap_chk(1, b_phi1, b_phi2, DB);
      if (a_ack) ack_a++;
      if (b_ack) ack_b++;
      if (prev_b_cnt == 16'hFFFF && b_cnt == 16'h0000) seen_wrap = 1'b1;
      if (a_cnt != prev_a_cnt) $display("tb: dut_a cycle done cnt=%04h ack=%0b", a_cnt, a_ack);
      if (b_cnt != prev_b_cnt) $display("tb: dut_b cycle done cnt=%04h ack=%0b", b_cnt, b_ack);
      prev_a_cnt = a_cnt;
      prev_b_cnt = b_cnt;
   end

   // Drive one cycle of stimulus and queue the outputs it should produce.
   task automatic cyc(input bit r, input bit s, input bit frc = 1'b0);
      @(negedge clk);
      if (frc) begin
         force dut_b.r_cycle_cnt = 16'hFFFE;
         #1;
         release dut_b.r_cycle_cnt;
         mb.cnt = 16'hFFFE;
      end
      run = r;
      step = s;
      ma = mdl_next(ma, r, s);
      mb = mdl_next(mb, r, s);
      qa.push_back(mdl_out(ma));
      qb.push_back(mdl_out(mb));
   endtask

   localparam obs_t RST_OBS = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};

   // Assert nRST between edges and check outputs react without a clock.
   task automatic do_reset(input bit expect_p1);
      @(posedge clk);
      #3;
      if (expect_p1) chk("pre-reset a phi1", 32'(a_phi1), 32'h1);
      rst_n = 1'b0; run = 1'b0; step = 1'b0;
      #1;
      chk("async reset a", 32'({a_phi1, a_nphi1, a_phi2, a_nphi2, a_halted, a_ack, a_cnt}), 32'(RST_OBS));
      chk("async reset b", 32'({b_phi1, b_nphi1, b_phi2, b_nphi2, b_halted, b_ack, b_cnt}), 32'(RST_OBS));
      ma = mdl_reset(HA, DA);
      mb = mdl_reset(HB, DB);
      qa.delete();
      qb.delete();
      had_ph[0] = 1'b0; had_ph[1] = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
   endtask

   initial begin
      int ea, eb, aa, ab;
      bit r, s;
      ma = mdl_reset(HA, DA);
      mb = mdl_reset(HB, DB);
      had_ph[0] = 1'b0; had_ph[1] = 1'b0;
      low_run[0] = 0; low_run[1] = 0; prev_any[0] = 1'b0; prev_any[1] = 1'b0;

      // Reset values while nRST is held from time zero.
      repeat (2) @(posedge clk);
      #1;
      chk("reset a", 32'({a_phi1, a_nphi1, a_phi2, a_nphi2, a_halted, a_ack, a_cnt}), 32'(RST_OBS));
      chk("reset b", 32'({b_phi1, b_nphi1, b_phi2, b_nphi2, b_halted, b_ack, b_cnt}), 32'(RST_OBS));
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // Free run: 18 master cycles of phase output finish 3 default periods.
      repeat (19) cyc(1'b1, 1'b0);
      @(posedge clk);
      #2;
      chk("a cnt after 18 cycles", 32'(a_cnt), 32'd3);
      chk("b cnt after 18 cycles", 32'(b_cnt), 32'd1);

      // Drop RUN: current cycles complete, then park with no STEP_ACK.
      aa = ack_a; ab = ack_b;
      repeat (16) cyc(1'b0, 1'b0);
      #6;
      chk("a halted after run drop", 32'(a_halted), 32'h1);
      chk("b halted after run drop", 32'(b_halted), 32'h1);
      chk("a no ack on run drop", 32'(ack_a), 32'(aa));

      // RUN dropped while dut_a is in P2 (fourth edge after leaving HALT).
      repeat (4) cyc(1'b1, 1'b0);
      repeat (14) cyc(1'b0, 1'b0);
      #6;
      chk("a no ack after P2 drop", 32'(ack_a), 32'(aa));

      // Two single steps, STEP held high 10 cycles each time.
      for (int k = 0; k < 2; k++) begin
         ea = int'(ma.cnt) + 1; eb = int'(mb.cnt) + 1;
         aa = ack_a; ab = ack_b;
         repeat (10) cyc(1'b0, 1'b1);
         repeat (14) cyc(1'b0, 1'b0);
         #6;
         chk("a cnt after step", 32'(a_cnt), 32'(ea));
         chk("b cnt after step", 32'(b_cnt), 32'(eb));
         chk("a one ack per step", 32'(ack_a), 32'(aa + 1));
         chk("b one ack per step", 32'(ack_b), 32'(ab + 1));
      end

      // STEP edges during free run, then RUN and STEP together in HALT.
      aa = ack_a; ab = ack_b;
      for (int k = 0; k < 24; k++) cyc(1'b1, (k % 3) == 1);
      repeat (14) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      repeat (9) cyc(1'b1, 1'b1);
      repeat (14) cyc(1'b0, 1'b0);
      #6;
      chk("a steps ignored while running", 32'(ack_a), 32'(aa));
      chk("b steps ignored while running", 32'(ack_b), 32'(ab));

      // Reset in the middle of P1, then restart with RUN held.
      cyc(1'b1, 1'b0);
      do_reset(1'b1);
      repeat (20) cyc(1'b1, 1'b0);

      // Counter wrap on dut_b after preloading it near the top.
      cyc(1'b1, 1'b0, 1'b1);
      repeat (45) cyc(1'b1, 1'b0);
      #6;
      chk("b cycle count wrapped", 32'(seen_wrap), 32'h1);

      // Random RUN/STEP traffic against the model.
      r = 1'b0; s = 1'b0;
      for (int k = 0; k < 700; k++) begin
         if ($urandom_range(0, 19) == 0) r = ~r;
         if ($urandom_range(0, 3) == 0) s = ~s;
         cyc(r, s);
      end
      repeat (25) cyc(1'b0, 1'b0);
      @(posedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/two_phase_clkgen.md
# two_phase_clkgen

Generates the complementary, non-overlapping two-phase clocks that drive the core's latch-based storage. Every latch takes a CLK/nCLK enable pair. This block produces two such pairs from one master clock: PHI1/nPHI1 for the master stage and PHI2/nPHI2 for the slave stage. It also provides run/halt/single-step control for bring-up and debug.

## Interface
- HIGH_CYC, default 2: master-clock cycles each phase is high; legal range 1..2^CNT_W-1.
- DEAD_CYC, default 1: master-clock cycles with both phases low, between phases; legal range 1..2^CNT_W-1. 0 is illegal and is rejected at elaboration.
- CNT_W, default 4: width of the internal phase counter.
- CLK  in  1  master clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- RUN  in  1  level; 1 = free-run phase cycles.
- STEP  in  1  a rising edge while halted runs exactly one phase cycle.
- PHI1, nPHI1  out  1  phase-1 enable pair; nPHI1 is always the complement of PHI1.
- PHI2, nPHI2  out  1  phase-2 enable pair; nPHI2 is always the complement of PHI2.
- HALTED  out  1  1 while parked in HALT.
- STEP_ACK  out  1  one-cycle pulse when a stepped cycle completes.
- CYCLE_CNT  out  16  count of completed phase cycles, wrapping.

## Operation
- States: HALT, P1, D1, P2, D2.
  - HALT: all phases low.
  - P1: PHI1 high.
  - D1: dead time after PHI1.
  - P2: PHI2 high.
  - D2: dead time after PHI2.
- HALT -> P1 when RUN=1, or when a STEP rising edge is detected. STEP is compared with a registered copy of itself.
- P1 lasts HIGH_CYC cycles, D1 lasts DEAD_CYC, P2 lasts HIGH_CYC, D2 lasts DEAD_CYC. A down-counter loads on each state entry.
- At the end of D2:
  - CYCLE_CNT increments, wrapping 0xFFFF -> 0x0000.
  - If RUN=1 and the cycle was not a step, go to P1.
  - Otherwise go to HALT.
  - If the cycle was a step, pulse STEP_ACK for 1 cycle, coincident with the entry into HALT.
- Phases are never truncated. Dropping RUN mid-cycle finishes the current cycle through D2, then halts.
- A STEP edge while RUN=1 or while not in HALT is ignored; it is neither queued nor acknowledged.
- If RUN=1 and a STEP edge arrive together in HALT, run mode wins and STEP_ACK is not generated.
- A stepped cycle executes one cycle even if RUN rises during it. It then returns to HALT, and RUN takes effect from HALT on the next edge.
- Reset values: state HALT, PHI1=PHI2=0, nPHI1=nPHI2=1, HALTED=1, STEP_ACK=0, CYCLE_CNT=0. The registered copy of STEP also resets to 0, so a STEP held high through reset does not trigger a step.
- Reset mid-cycle forces these values immediately, without waiting for a clock edge.

## Timing
- All outputs come straight from flops: no decode glitches, and each pair is complementary on every cycle.
- RUN sampled 1 at rising edge k while in HALT -> PHI1=1 and HALTED=0 from edge k through edge k+HIGH_CYC.
- Period = 2*(HIGH_CYC+DEAD_CYC) master cycles; 6 with the defaults.
- Non-overlap: PHI1 and PHI2 are never both high. Between a falling phase and the next rising phase there are at least DEAD_CYC master cycles with both low.
- STEP edge detection adds 1 cycle: STEP rising at edge k (sampled) -> PHI1=1 after edge k+1.
- After deassertion of nRST, the first active edge is evaluated normally.

## Structure
- Shared package clkgen_pkg holds:
  - the state enum (HALT, P1, D1, P2, D2);
  - the CYCLE_CNT width constant (16);
  - the phase-output encoding per state.
- One sub-module, phase_counter: a CNT_W-bit loadable down-counter with a load input, a load value, and a zero flag.
- The main module holds the FSM, STEP edge detect, output registers, and CYCLE_CNT.
- Rough size: 150-250 lines total.

## Test plan
- Reset then RUN=1 held, defaults:
  - PHI1 high 2 cycles, both low 1, PHI2 high 2, both low 1, repeating with period 6.
  - CYCLE_CNT=3 after 18 cycles.
  - nPHIx always equals the complement of PHIx.
- RUN dropped during P2:
  - P2 and D2 complete normally.
  - HALTED=1 the cycle after D2 ends.
  - No STEP_ACK.
- Single step from HALT:
  - STEP 0->1 held high for 10 cycles -> exactly one phase cycle.
  - STEP_ACK pulses 1 cycle; CYCLE_CNT +1.
  - A second cycle runs only after STEP goes low and then high again.
- STEP during free run, and STEP with RUN together:
  - Both ignored; no STEP_ACK.
  - Phase sequence is uninterrupted.
- nRST asserted mid-P1 between clock edges:
  - PHI1=0, nPHI1=1, HALTED=1 immediately.
  - CYCLE_CNT=0.
  - After release with RUN=1, P1 restarts with full HIGH_CYC.
- HIGH_CYC=3, DEAD_CYC=2:
  - Period 10.
  - A monitor checks PHI1&PHI2 is never true and the gap between phases is at least 2 cycles.
  - CYCLE_CNT wraps 0xFFFF -> 0x0000 when forced near the limit.
